// File: rtl/bus_arbiter_4_pkg.sv
// ----------------------------------------------------------------------------
// bus_arbiter_4_pkg
// Shared types and constants for the four-requester bus arbiter.
//   arb_state_t   : FSM state encoding (IDLE / GRANT / GAP)
//   MODE_FIXED/RR : values of the mode input
//   id_to_onehot  : converts a requester index into a one-hot grant vector
// ----------------------------------------------------------------------------
package bus_arbiter_4_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [1:0] id);
        logic [NUM_REQ-1:0] base;
        base         = {{(NUM_REQ-1){1'b0}}, 1'b1};
        id_to_onehot = base << id;
    endfunction

endpackage

// File: rtl/bus_arbiter_4_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_4_if
// Request/grant bundle between the requesting agents and the arbiter.
//   req[3:0]      : request vector, bit i = requester i
//   mode          : 0 = fixed priority, 1 = round-robin
//   grant[3:0]    : one-hot grant
//   grant_id[1:0] : binary index of the grantee (drives the resource mux)
//   grant_valid   : OR of grant
//   timeout       : one-cycle pulse when the hold limit revokes a grant
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface bus_arbiter_4_if;

    logic [3:0] req;
    logic       mode;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output req,
        output mode,
        input  grant,
        input  grant_id,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  mode,
        output grant,
        output grant_id,
        output grant_valid,
        output timeout
    );

endinterface

// File: rtl/bus_arbiter_4_pick.sv
// ----------------------------------------------------------------------------
// bus_arbiter_4_pick
// Combinational winner selection for the four-requester arbiter.
//   i_req[3:0]     : current request vector
//   i_mode         : MODE_FIXED -> highest set index wins
//                    MODE_RR    -> first set bit scanning up from last_id+1
//   i_last_id[1:0] : index of the most recently released grantee
//   o_win_id[1:0]  : winning index (meaningful only when o_win_any=1)
//   o_win_any      : at least one request is present
// ----------------------------------------------------------------------------
module bus_arbiter_4_pick
    import bus_arbiter_4_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic       i_mode,
    input  logic [1:0] i_last_id,
    output logic [1:0] o_win_id,
    output logic       o_win_any
);

    logic [1:0] w_start;
    logic [7:0] w_req_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_fix_id;
    logic [1:0] w_rr_off;

    // Doubling the vector lets a plain part-select perform the rotation:
    // w_rot[k] = i_req[(w_start + k) mod 4].
    assign w_start   = i_last_id + 2'd1;
    assign w_req_dbl = {i_req, i_req};
    assign w_rot     = w_req_dbl[w_start +: 4];

    // Fixed priority: later iterations overwrite, so the highest set index wins.
    always_comb begin
        w_fix_id = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req[i]) begin
                w_fix_id = 2'(i);
            end
        end
    end

    // Round-robin: scan downward so the lowest set offset wins.
    always_comb begin
        w_rr_off = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_rr_off = 2'(k);
            end
        end
    end

    assign o_win_id  = (i_mode == MODE_RR) ? (w_start + w_rr_off) : w_fix_id;
    assign o_win_any = |i_req;

endmodule

// File: rtl/bus_arbiter_4.sv
// ----------------------------------------------------------------------------
// bus_arbiter_4
// Four-requester arbiter for one shared resource. A grant is held until the
// owner drops its request or until MAX_HOLD cycles have elapsed, and every
// grant is followed by one dead (GAP) cycle for bus turnaround.
//   clk     : system clock, rising edge
//   rst     : asynchronous, active-high reset
//   arb_bus : bus_arbiter_4_if.slave (req, mode in; grant, grant_id,
//             grant_valid, timeout out - all outputs registered)
// Parameters:
//   MAX_HOLD : max consecutive grant cycles, 0 disables the limit
//   HOLD_W   : hold counter width, 2**HOLD_W must exceed MAX_HOLD
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant, no request seen; arbitrate every cycle
// ST_GRANT | grant asserted to r_grant_id; watch release / hold limit
// ST_GAP   | single dead cycle after a grant; arbitrate for the next one
// ----------------------------------------------------------------------------
module bus_arbiter_4
    import bus_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    bus_arbiter_4_if.slave  arb_bus
);

    localparam logic [HOLD_W-1:0] LP_MAX_HOLD = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] LP_HOLD_SAT = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] LP_HOLD_ONE = HOLD_W'(1);

    arb_state_t        r_state;
    logic [3:0]        r_grant;
    logic [1:0]        r_grant_id;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [1:0]        r_last_id;
    logic              r_timeout;

    arb_state_t        w_state_nxt;
    logic [3:0]        w_grant_nxt;
    logic [1:0]        w_grant_id_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [1:0]        w_last_id_nxt;
    logic              w_timeout_nxt;

    logic [1:0]        w_win_id;
    logic              w_win_any;
    logic              w_owner_req;
    logic              w_hold_expire;
    logic              w_release;

    bus_arbiter_4_pick u_pick (
        .i_req     (arb_bus.req),
        .i_mode    (arb_bus.mode),
        .i_last_id (r_last_id),
        .o_win_id  (w_win_id),
        .o_win_any (w_win_any)
    );

    // Only the current owner's request bit matters while granted; other
    // requesters and mode changes cannot preempt.
    assign w_owner_req   = arb_bus.req[r_grant_id];
    assign w_hold_expire = (MAX_HOLD != 0) && (r_hold_cnt == LP_MAX_HOLD);
    assign w_release     = !w_owner_req || w_hold_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= 4'b0000;
            r_grant_id <= 2'd0;
            r_hold_cnt <= '0;
            r_last_id  <= 2'd3;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last_id  <= w_last_id_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                w_state_nxt = w_win_any ? ST_GRANT : ST_IDLE;
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_hold_nxt     = r_hold_cnt;
        w_last_id_nxt  = r_last_id;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_win_any) begin
                    w_grant_nxt    = id_to_onehot(w_win_id);
                    w_grant_id_nxt = w_win_id;
                    w_hold_nxt     = LP_HOLD_ONE;
                end else begin
                    w_grant_nxt    = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_grant_nxt   = 4'b0000;
                    w_last_id_nxt = r_grant_id;
                    // A dropped request takes precedence: the pulse only
                    // marks grants the owner still wanted.
                    w_timeout_nxt = w_owner_req && w_hold_expire;
                end else if (r_hold_cnt != LP_HOLD_SAT) begin
                    w_hold_nxt    = r_hold_cnt + LP_HOLD_ONE;
                end
            end
            default: begin
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    assign arb_bus.grant       = r_grant;
    assign arb_bus.grant_id    = r_grant_id;
    assign arb_bus.grant_valid = |r_grant;
    assign arb_bus.timeout     = r_timeout;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter_4
// Drives two arbiters (MAX_HOLD=8 and MAX_HOLD=3) with the same stimulus.
// A reference model predicts each cycle's outputs; predictions are queued
// when stimulus is applied and popped after the clock edge for comparison.
// ----------------------------------------------------------------------------
module tb_bus_arbiter_4;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] gid;
        logic       valid;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bus_arbiter_4_if if_a();
    bus_arbiter_4_if if_b();

    bus_arbiter_4 #(.MAX_HOLD(8), .HOLD_W(4)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .arb_bus (if_a)
    );

    bus_arbiter_4 #(.MAX_HOLD(3), .HOLD_W(4)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .arb_bus (if_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];

    int         n_checks = 0;
    int         n_pass   = 0;

    int         m_state [2];
    logic [1:0] m_gid   [2];
    logic [1:0] m_last  [2];
    int         m_hold  [2];
    logic       m_valid [2];
    logic       m_to    [2];
    int         m_max   [2] = '{8, 3};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_pick(input logic [3:0] r, input logic m, input logic [1:0] last);
        logic [1:0] id;
        ref_pick = 2'd0;
        if (!m) begin
            for (int i = 0; i < 4; i++) begin
                if (r[i]) ref_pick = 2'(i);
            end
        end else begin
            for (int k = 4; k >= 1; k--) begin
                id = 2'(int'(last) + k);
                if (r[id]) ref_pick = id;
            end
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0;
            m_gid[d]   = 2'd0;
            m_last[d]  = 2'd3;
            m_hold[d]  = 0;
            m_valid[d] = 1'b0;
            m_to[d]    = 1'b0;
        end
    endtask

    // state: 0 = idle, 1 = granted, 2 = dead gap
    task automatic model_step(input int d, input logic [3:0] r, input logic m);
        m_to[d] = 1'b0;
        if (m_state[d] != 1) begin
            if (r != 4'b0000) begin
                m_gid[d]   = ref_pick(r, m, m_last[d]);
                m_valid[d] = 1'b1;
                m_hold[d]  = 1;
                m_state[d] = 1;
            end else begin
                m_valid[d] = 1'b0;
                m_state[d] = 0;
            end
        end else if (!r[m_gid[d]]) begin
            m_valid[d] = 1'b0;
            m_last[d]  = m_gid[d];
            m_state[d] = 2;
        end else if (m_max[d] != 0 && m_hold[d] == m_max[d]) begin
            m_valid[d] = 1'b0;
            m_last[d]  = m_gid[d];
            m_to[d]    = 1'b1;
            m_state[d] = 2;
        end else if (m_hold[d] < 15) begin
            m_hold[d]++;
        end
    endtask

    function automatic exp_t model_out(input int d);
        exp_t       e;
        logic [3:0] one;
        one     = 4'b0001;
        e.grant = m_valid[d] ? (one << m_gid[d]) : 4'b0000;
        e.gid   = m_gid[d];
        e.valid = m_valid[d];
        e.to    = m_to[d];
        return e;
    endfunction

    task automatic run_cycle(input logic [3:0] r, input logic m);
        exp_t obs_a, obs_b, exp_a, exp_b;
        if_a.req  = r;
        if_a.mode = m;
        if_b.req  = r;
        if_b.mode = m;
        model_step(0, r, m);
        q_a.push_back(model_out(0));
        model_step(1, r, m);
        q_b.push_back(model_out(1));
        @(posedge clk);
        #1;
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        obs_a = {if_a.grant, if_a.grant_id, if_a.grant_valid, if_a.timeout};
        obs_b = {if_b.grant, if_b.grant_id, if_b.grant_valid, if_b.timeout};
        check_eq("hold8_outputs", 32'(obs_a), 32'(exp_a));
        check_eq("hold3_outputs", 32'(obs_b), 32'(exp_b));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_a"}, 32'({if_a.grant, if_a.grant_id, if_a.grant_valid, if_a.timeout}), 32'd0);
        check_eq({tag, "_b"}, 32'({if_b.grant, if_b.grant_id, if_b.grant_valid, if_b.timeout}), 32'd0);
    endtask

    initial begin
        logic [3:0] r_rand;
        logic       m_rand;

        if_a.req  = 4'b0000;
        if_a.mode = 1'b0;
        if_b.req  = 4'b0000;
        if_b.mode = 1'b0;
        rst       = 1'b1;
        model_reset();
        #12;
        check_idle_outputs("reset_state");
        #1;
        rst = 1'b0;

        // Fixed priority pick, release, dead gap, next grant.
        run_cycle(4'b0110, 1'b0);
        check_eq("fixed_first_grant", 32'(if_a.grant), 32'h4);
        check_eq("fixed_first_id", 32'(if_a.grant_id), 32'd2);
        run_cycle(4'b0110, 1'b0);
        run_cycle(4'b0010, 1'b0);
        check_eq("release_dead_cycle", 32'(if_a.grant), 32'h0);
        run_cycle(4'b0010, 1'b0);
        check_eq("after_gap_grant", 32'(if_a.grant), 32'h2);
        check_eq("after_gap_id", 32'(if_a.grant_id), 32'd1);
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b0);

        // Hold limit with a single persistent requester.
        for (int i = 0; i < 20; i++) begin
            run_cycle(4'b1000, 1'b0);
            if (i == 7) check_eq("hold8_last_grant_cycle", 32'(if_a.grant), 32'h8);
            if (i == 8) check_eq("hold8_timeout_pulse", 32'({if_a.grant, if_a.timeout}), 32'h01);
            if (i == 9) check_eq("hold8_regrant", 32'({if_a.grant, if_a.timeout}), 32'h10);
        end
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b0);

        // Round-robin rotation under the 3-cycle hold limit.
        for (int i = 0; i < 20; i++) begin
            run_cycle(4'b1111, 1'b1);
            if (i == 0)  check_eq("rr_first_id", 32'(if_b.grant_id), 32'd0);
            if (i == 3)  check_eq("rr_timeout_gap", 32'({if_b.grant, if_b.timeout}), 32'h01);
            if (i == 4)  check_eq("rr_second_id", 32'(if_b.grant_id), 32'd1);
            if (i == 12) check_eq("rr_fourth_id", 32'(if_b.grant_id), 32'd3);
            if (i == 16) check_eq("rr_wrap_id", 32'(if_b.grant_id), 32'd0);
        end
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b0);

        // No preemption by a higher-priority request.
        for (int i = 0; i < 3; i++) run_cycle(4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_cycle(4'b1001, 1'b0);
            check_eq("no_preempt", 32'(if_a.grant), 32'h1);
        end
        run_cycle(4'b1000, 1'b0);
        check_eq("preempt_gap", 32'(if_a.grant), 32'h0);
        run_cycle(4'b1000, 1'b0);
        check_eq("preempt_next", 32'(if_a.grant), 32'h8);
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b0);

        // One-cycle request pulse yields a one-cycle grant.
        run_cycle(4'b0100, 1'b0);
        check_eq("pulse_grant", 32'(if_a.grant), 32'h4);
        run_cycle(4'b0000, 1'b0);
        check_eq("pulse_release", 32'(if_a.grant), 32'h0);
        run_cycle(4'b0000, 1'b0);

        // Random traffic with sticky requests so grants get held.
        r_rand = 4'b0000;
        m_rand = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r_rand = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) m_rand = ~m_rand;
            run_cycle(r_rand, m_rand);
        end
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b0);

        // Asynchronous reset in the middle of a grant.
        run_cycle(4'b0010, 1'b0);
        run_cycle(4'b0010, 1'b0);
        check_eq("pre_reset_grant", 32'(if_a.grant), 32'h2);
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cycle(4'b1111, 1'b1);
        check_eq("post_reset_rr_a", 32'({if_a.grant, if_a.grant_id}), 32'h04);
        check_eq("post_reset_rr_b", 32'({if_b.grant, if_b.grant_id}), 32'h04);
        for (int i = 0; i < 6; i++) run_cycle(4'b1111, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
